// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code sequence source: FSM states,
// the binary-to-Gray mapping and the default word width.
package gray_pkg;

  localparam int unsigned GRAY_DEF_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Width-agnostic: callers zero-extend into 32 bits and keep the low W bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_seq_gen_bin2gray_conv.sv
// Combinational W-bit binary-to-Gray encoder; mirror of g2b_conv.
module bin2gray_conv
  import gray_pkg::*;
#(
  parameter int unsigned W = GRAY_DEF_W
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  logic [31:0] gray_full;

  always_comb begin
    gray_full = bin2gray(32'(bin));
    gray      = gray_full[W-1:0];
  end

endmodule

// File: rtl/gray_seq_gen.sv
// Emits a programmable run of W-bit Gray codes over a valid/ready stream,
// driven by an internal binary counter re-encoded on every transfer.
module gray_seq_gen
  import gray_pkg::*;
#(
  parameter int unsigned W = GRAY_DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         dir,
  input  logic [W-1:0] seed,
  input  logic [W-1:0] len,
  output logic [0:W-1] gray,
  output logic         valid,
  input  logic         ready,
  output logic         busy,
  output logic         done
);

  state_e       state_q, state_d;
  logic [W-1:0] bin_q, bin_d;
  logic [W:0]   rem_q, rem_d;
  logic         dir_q, dir_d;
  logic [W-1:0] gray_q, gray_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d   = seed;
          rem_d   = (len == '0) ? {1'b1, {W{1'b0}}} : {1'b0, len};
          dir_d   = dir;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (valid_q && ready) begin
          if (rem_q > (W+1)'(1)) begin
            bin_d = dir_q ? (bin_q - W'(1)) : (bin_q + W'(1));
            rem_d = rem_q - (W+1)'(1);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Gray is always the encoding of the next bin; holding bin holds the word.
  bin2gray_conv #(.W(W)) u_enc (
    .bin  (bin_d),
    .gray (gray_d)
  );

  always_comb begin
    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      gray_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign gray  = gray_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_gray_seq_gen.sv
// Self-checking bench for gray_seq_gen (W=4): directed table, backpressure,
// ignored start, mid-run reset and randomized runs against a reference model.
module tb_gray_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       dir;
  logic [3:0] seed;
  logic [3:0] len;
  logic [0:3] gray_o;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  gray_seq_gen #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .dir   (dir),
    .seed  (seed),
    .len   (len),
    .gray  (gray_o),
    .valid (valid),
    .ready (ready),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] seed;
    logic [3:0] len;
    logic       dir;
    int         rdy_mode;
    logic [3:0] exp_first;
    logic [3:0] exp_last;
    int         exp_count;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: k-th word is the Gray code of (seed +/- k) mod 16.
  function automatic logic [3:0] ref_word(input logic [3:0] s, input int k, input logic d);
    int b;
    b = d ? (int'(s) - k) : (int'(s) + k);
    b = b & 15;
    return 4'(b ^ (b >> 1));
  endfunction

  // rdy_mode: 0 ready always, 1 random ready, 2 stall 3 cycles after first
  // transfer, 3 like 0 but pulse start with different inputs mid-run.
  task automatic run_check(input logic [3:0] s, input logic [3:0] l, input logic d,
                           input int rdy_mode, output logic [3:0] first,
                           output logic [3:0] last, output int count);
    int         n;
    int         idx;
    int         cycles;
    int         stall;
    logic [3:0] g;
    logic [3:0] prev;
    bit         fin;
    n      = (l == 0) ? 16 : int'(l);
    idx    = 0;
    cycles = 0;
    stall  = 0;
    fin    = 0;
    count  = 0;
    first  = '0;
    last   = '0;
    prev   = '0;
    @(negedge clk);
    start = 1'b1; seed = s; len = l; dir = d; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seed = 4'($urandom); len = 4'($urandom); dir = 1'($urandom);
    while (!fin && cycles < 300) begin
      g = gray_o;
      if (start) start = 1'b0;
      if (idx < n) begin
        chk("run_valid", int'(valid), 1);
        chk("run_busy", int'(busy), 1);
        chk("run_done_low", int'(done), 0);
        chk("run_word", int'(g), int'(ref_word(s, idx, d)));
        if (idx > 0 && stall == 0) chk("one_bit_step", $countones(g ^ prev), 1);
        case (rdy_mode)
          1: ready = 1'($urandom);
          2: begin
            if (idx == 1 && stall < 3) begin ready = 1'b0; stall++; end
            else ready = 1'b1;
          end
          3: begin
            ready = 1'b1;
            if (idx == 1) begin
              start = 1'b1; seed = ~s; len = 4'd15; dir = ~d;
            end
          end
          default: ready = 1'b1;
        endcase
        if (ready) begin
          if (idx == 0) first = g;
          last = g;
          prev = g;
          count++;
          idx++;
          stall = (rdy_mode == 2) ? stall : 0;
          if (rdy_mode == 2 && idx > 1) stall = 3;
        end
      end else begin
        chk("done_pulse", int'(done), 1);
        chk("done_valid_low", int'(valid), 0);
        chk("done_busy_low", int'(busy), 0);
        @(negedge clk);
        chk("after_done_low", int'(done), 0);
        chk("after_valid_low", int'(valid), 0);
        chk("after_busy_low", int'(busy), 0);
        fin = 1;
      end
      if (!fin) begin
        @(negedge clk);
        cycles++;
      end
    end
    if (!fin) chk("run_timeout", 1, 0);
    ready = 1'b1;
  endtask

  vec_t       vecs[6];
  logic [3:0] f, la;
  int         c;

  initial begin
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; seed = '0; len = '0; ready = 1'b1;
    #1;
    chk("reset_gray", int'(gray_o), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //        seed     len    dir  mode first  last   count
    vecs[0] = '{4'h0, 4'd4, 1'b0, 0, 4'b0000, 4'b0010, 4};
    vecs[1] = '{4'hB, 4'd3, 1'b1, 0, 4'b1110, 4'b1101, 3};
    vecs[2] = '{4'hF, 4'd2, 1'b0, 0, 4'b1000, 4'b0000, 2};
    vecs[3] = '{4'h0, 4'd0, 1'b0, 0, 4'b0000, 4'b1000, 16};
    vecs[4] = '{4'h0, 4'd4, 1'b0, 2, 4'b0000, 4'b0010, 4};
    vecs[5] = '{4'h5, 4'd4, 1'b0, 3, 4'b0111, 4'b1100, 4};
    for (int i = 0; i < 6; i++) begin
      run_check(vecs[i].seed, vecs[i].len, vecs[i].dir, vecs[i].rdy_mode, f, la, c);
      chk($sformatf("vec%0d_first", i), int'(f), int'(vecs[i].exp_first));
      chk($sformatf("vec%0d_last", i), int'(la), int'(vecs[i].exp_last));
      chk($sformatf("vec%0d_count", i), c, vecs[i].exp_count);
    end

    // Reset mid-run: outputs clear immediately, no done pulse, then idle.
    @(negedge clk);
    start = 1'b1; seed = 4'h3; len = 4'd8; dir = 1'b0; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_valid", int'(valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_gray", int'(gray_o), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_done", int'(done), 0);
      chk("post_rst_valid", int'(valid), 0);
      chk("post_rst_busy", int'(busy), 0);
    end

    for (int r = 0; r < 20; r++) begin
      logic [3:0] rs, rl;
      logic       rd;
      rs = 4'($urandom);
      rl = 4'($urandom);
      rd = 1'($urandom);
      run_check(rs, rl, rd, 1, f, la, c);
      chk("rnd_count", c, (rl == 0) ? 16 : int'(rl));
      chk("rnd_last", int'(la), int'(ref_word(rs, ((rl == 0) ? 16 : int'(rl)) - 1, rd)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_seq_gen.md
# gray_seq_gen

Sequential Gray-code source that emits a programmable run of W-bit Gray codes over a valid/ready stream. It sits directly upstream of `g2b_conv` and supplies the Gray words that the converter turns back into binary. A binary counter runs internally and is re-encoded to Gray on every transfer, so consecutive emitted words differ in exactly one bit.

## Interface
- `W`, default 4: Gray/binary word width.
- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a run; sampled only in IDLE.
- `dir`  in  1  0 = count up, 1 = count down; latched at start.
- `seed`  in  W  binary value of the first code; latched at start.
- `len`  in  W  number of codes to emit; 0 means 2^W; latched at start.
- `gray`  out  [0:W-1]  current Gray word; bit 0 is the MSB, which matches the `g2b_conv` bit ordering.
- `valid`  out  1  `gray` holds a word to transfer.
- `ready`  in  1  consumer accepts the word this cycle.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse after the final transfer.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - `valid` = 0, `busy` = 0.
  - On `start` = 1:
    - bin ← `seed`.
    - rem ← (`len` == 0 ? 2^W : `len`).
    - dir_q ← `dir`.
    - `gray` ← bin2gray(`seed`).
    - Go to RUN.
- **RUN**
  - `valid` = 1, `busy` = 1.
  - Transfer occurs when `valid` && `ready`.
  - On transfer with rem > 1:
    - bin ← bin ± 1, modulo 2^W (wraps 2^W−1 → 0 going up, 0 → 2^W−1 going down).
    - rem ← rem − 1.
    - `gray` ← bin2gray(next bin).
  - On transfer with rem == 1: go to DONE. `gray` holds its last value.
- **DONE**
  - `done` = 1 and `valid` = 0 for exactly one cycle, then go to IDLE.
- Conversion: bin2gray(b) is b XOR (b >> 1). The MSB passes through unchanged.
- rem is W+1 bits wide so it can hold 2^W.
- Backpressure: while `valid` && !`ready`, `gray`, bin and rem are frozen.
- `start` in RUN or DONE is ignored. Mode inputs are not re-sampled mid-run.
- Changing `seed`, `len` or `dir` after the start cycle has no effect on the current run.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low): state = IDLE, `gray` = 0, `valid` = 0, `busy` = 0, `done` = 0, bin = 0, rem = 0.
- Reset asserted mid-run aborts the run. No `done` pulse is produced.
- Start latency: if `start` is sampled at edge k, `valid` and the first `gray` word are visible after edge k, i.e. in cycle k+1.
- Throughput: with `ready` held high, one word per cycle.
- Last word: the final transfer at edge t gives `done` = 1 in cycle t+1 and IDLE in cycle t+2.
- Back-to-back runs: the earliest accepted new `start` is in cycle t+2.
- Combinational paths: none from `ready` to `valid` or `gray`. All outputs are registered.

## Structure
- Shared package `gray_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - function `bin2gray`;
  - constant `GRAY_DEF_W` = 4.
- Sub-module `bin2gray_conv` is the combinational W-bit encoder, instantiated once on the next-bin path. It is the mirror of `g2b_conv`.
- The top level contains the FSM, the counter and the output registers.

## Test plan
W = 4 for all scenarios. In the reset scenario, release of `rst_n` means it is returned high.

1. **Up run.**
   - Stimulus: `seed` = 0, `len` = 4, `dir` = 0, `ready` = 1.
   - Required: `gray` = 0000, 0001, 0011, 0010 on 4 consecutive cycles, then `done` = 1 for one cycle.
2. **Down run.**
   - Stimulus: `seed` = 1011, `len` = 3, `dir` = 1.
   - Required: `gray` = 1110, 1111, 1101.
3. **Wrap-around.**
   - Stimulus: `seed` = 1111, `len` = 2, `dir` = 0.
   - Required: `gray` = 1000, then 0000.
4. **Full length.**
   - Stimulus: `len` = 0, `seed` = 0, up.
   - Required: exactly 16 transfers; each adjacent pair differs in 1 bit; last word = 1000; `done` once.
5. **Backpressure.**
   - Stimulus: after the first transfer of scenario 1, `ready` = 0 for 3 cycles.
   - Required: `gray` stays 0001 and `valid` stays 1; the sequence resumes unchanged after `ready` = 1.
6. **Reset and ignored start.**
   - Stimulus: `start` pulsed during RUN; then `rst_n` pulled low mid-run.
   - Required for the `start` pulse: the sequence is unaffected.
   - Required for the reset: `gray` = 0, `valid` = 0, `busy` = 0 immediately; no `done` pulse; IDLE after `rst_n` is released.
